snapshot_ctrl: RTL and testbench
================================

Name: snapshot_ctrl

Overview:
Capture sequencer for the ADC snapshot buffer. It decodes the control words published by the AXI-lite register block (config_snapshot, offset_snapshot). It arms on software request, waits for a software or external trigger, waits a programmable post-trigger delay, then writes exactly 2**ADDR_WIDTH valid samples into the snapshot BRAM. It exports a status word and a done pulse for software polling and interrupt.

Parameters:
DATA_WIDTH, 32, sample width written to BRAM
ADDR_WIDTH, 10, BRAM address width; the capture length is 2**ADDR_WIDTH samples (ADDR_WIDTH <= 15)

Ports:
axi_clock  in  1  single clock for the block
rst  in  1  synchronous, active-low reset
config_snapshot  in  32  [0] arm, [1] sw_trig, [2] ext_trig_en, [31:3] ignored
offset_snapshot  in  32  post-trigger delay in clock cycles (unsigned)
ext_trig  in  1  external trigger; already synchronous to axi_clock
din  in  DATA_WIDTH  sample stream
din_valid  in  1  sample qualifier
bram_we  out  1  BRAM write enable
bram_addr  out  ADDR_WIDTH  BRAM write address
bram_din  out  DATA_WIDTH  BRAM write data
status  out  32  [2:0] state, [3] done, [4] trig_src (1 = ext), [31:16] samples written (zero-extended)
done_pulse  out  1  single-cycle pulse on entry to DONE

Behaviour:
- Reset (rst == 0 at a clock edge):
  - state = IDLE; bram_we, bram_addr, bram_din, status and done_pulse = 0.
  - The delay counter and sample counter = 0.
  - The edge-history registers for arm, sw_trig and ext_trig are set to 1. A level held high through reset therefore produces no edge.
- Edge detection: an edge = current input high AND history register low. History registers update every cycle.
- State encoding: IDLE = 0, ARMED = 1, DELAY = 2, CAPTURE = 3, DONE = 4.
- IDLE:
  - arm rising edge -> ARMED next cycle; clear the sample counter, done and trig_src.
  - Triggers are ignored and are not latched.
- ARMED:
  - arm == 0 -> IDLE.
  - Otherwise a trigger -> DELAY (offset != 0) or CAPTURE (offset == 0).
  - Trigger = sw_trig rising edge, OR ext_trig rising edge while ext_trig_en == 1.
  - trig_src = 1 only if the ext edge occurred and the sw edge did not in the same cycle.
- DELAY:
  - The counter loads offset_snapshot on entry and decrements each cycle.
  - It leaves for CAPTURE in the cycle the counter reaches 1.
  - Trigger detected at cycle t with offset D -> state == CAPTURE at cycle t+1+D.
  - arm == 0 -> IDLE.
- CAPTURE:
  - Each cycle with din_valid == 1, one sample is written at address = sample counter, and the counter increments.
  - After the write at address 2**ADDR_WIDTH-1 -> DONE next cycle. No further writes occur; no wrap-around.
  - arm == 0 -> IDLE; samples already written remain in BRAM.
- DONE:
  - done = 1 and the sample count is held.
  - arm == 0 -> IDLE. done stays set until the next arm edge clears it.
  - Re-arming requires arm to go low and then high again.
- Precedence within a cycle: reset > disarm (arm == 0) > trigger/capture progress.
- Write port timing:
  - bram_we, bram_addr and bram_din are registered, one cycle after the din/din_valid sample.
  - bram_we = 0 in every state other than CAPTURE.
- done_pulse: asserted for exactly one cycle, registered, coincident with status[2:0] first reading 4.
- Status:
  - status is registered and reflects the state one cycle after any transition.
  - The sample count occupies [16+ADDR_WIDTH:16]; it reads 2**ADDR_WIDTH in DONE.
- Mid-capture changes: a change of offset_snapshot or ext_trig_en during DELAY or CAPTURE has no effect on the current capture.
- Reset mid-capture: takes effect at the next edge; no further bram_we.

Test Plan:
1. Reset with config = 0x1 held high -> state stays IDLE (0), no arm edge. Drop arm, then raise it -> status[2:0] = 1.
2. Arm, offset = 0, sw_trig edge at cycle t, din_valid = 1 continuously with din = counter -> CAPTURE at t+1. 1024 writes with addresses 0..1023 and bram_din equal to the sampled din. DONE with status = 0x0400_000C. One done_pulse.
3. Arm, offset = 5, ext_trig_en = 1, ext_trig edge at t -> CAPTURE at t+6, status[4] = 1. With ext_trig_en = 0 the ext edge is ignored and the state stays ARMED.
4. Capture with din_valid toggling 1/0 -> exactly 1024 writes, contiguous addresses, no writes on invalid cycles.
5. Clear arm after 300 samples -> IDLE next cycle, bram_we = 0, no done_pulse. Re-arm -> sample count reads 0.
6. Assert rst = 0 during CAPTURE -> next cycle all outputs = 0 and state = IDLE. sw_trig and ext edges arriving in IDLE are ignored, and a later arm does not auto-trigger.

Source files
------------

// File: rtl/snapshot_ctrl.sv
// snapshot_ctrl: capture sequencer for the ADC snapshot buffer.
// Arms on a software edge, waits for a software/external trigger and a
// programmable post-trigger delay, then writes exactly 2**ADDR_WIDTH valid
// samples into the snapshot BRAM and reports status plus a done pulse.
module snapshot_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  axi_clock,
    input  logic                  rst,
    input  logic [31:0]           config_snapshot,
    input  logic [31:0]           offset_snapshot,
    input  logic                  ext_trig,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic [31:0]           status,
    output logic                  done_pulse
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_DELAY   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // One extra bit so the counter can hold the full capture length.
    localparam int                CNT_W     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t             r_state;
    logic               r_arm_hist;
    logic               r_sw_hist;
    logic               r_ext_hist;
    logic [31:0]        r_delay_cnt;
    logic [CNT_W-1:0]   r_sample_cnt;
    logic               r_done;
    logic               r_trig_src;

    state_t             w_next_state;
    logic               w_arm;
    logic               w_arm_edge;
    logic               w_sw_edge;
    logic               w_ext_hit;
    logic               w_trig;
    logic               w_write;
    logic [31:0]        w_delay_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_done_nxt;
    logic               w_src_nxt;
    logic               w_unused;

    // Control word decode and rising-edge detection against the history bits.
    assign w_arm      = config_snapshot[0];
    assign w_arm_edge = w_arm & ~r_arm_hist;
    assign w_sw_edge  = config_snapshot[1] & ~r_sw_hist;
    assign w_ext_hit  = ext_trig & ~r_ext_hist & config_snapshot[2];
    assign w_trig     = w_sw_edge | w_ext_hit;
    assign w_unused   = ^config_snapshot[31:3];

    // State register.
    always_ff @(posedge axi_clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and next-value logic; disarm has priority over any progress.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        w_next_state = r_state;
        w_write      = 1'b0;
        w_delay_nxt  = r_delay_cnt;
        w_cnt_nxt    = r_sample_cnt;
        w_done_nxt   = r_done;
        w_src_nxt    = r_trig_src;
        case (r_state)
            S_IDLE: begin
                if (w_arm_edge) begin
                    w_next_state = S_ARMED;
                    w_cnt_nxt    = '0;
                    w_done_nxt   = 1'b0;
                    w_src_nxt    = 1'b0;
                end
            end
            S_ARMED: begin
                if (!w_arm) begin
                    w_next_state = S_IDLE;
                end else if (w_trig) begin
                    w_src_nxt    = w_ext_hit & ~w_sw_edge;
                    w_delay_nxt  = offset_snapshot;
                    w_next_state = (offset_snapshot == 32'd0) ? S_CAPTURE : S_DELAY;
                end
            end
            S_DELAY: begin
                if (!w_arm) begin
                    w_next_state = S_IDLE;
                end else if (r_delay_cnt <= 32'd1) begin
                    w_next_state = S_CAPTURE;
                end else begin
                    w_delay_nxt = r_delay_cnt - 32'd1;
                end
            end
            S_CAPTURE: begin
                if (!w_arm) begin
                    w_next_state = S_IDLE;
                end else if (din_valid) begin
                    w_write   = 1'b1;
                    w_cnt_nxt = r_sample_cnt + 1'b1;
                    if (r_sample_cnt == LAST_ADDR) begin
                        w_next_state = S_DONE;
                        w_done_nxt   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!w_arm) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath registers, write port and status; status shows the new state.
    always_ff @(posedge axi_clock) begin
        if (!rst) begin
            // History bits start high so a level held through reset is no edge.
            r_arm_hist   <= 1'b1;
            r_sw_hist    <= 1'b1;
            r_ext_hist   <= 1'b1;
            r_delay_cnt  <= '0;
            r_sample_cnt <= '0;
            r_done       <= 1'b0;
            r_trig_src   <= 1'b0;
            bram_we      <= 1'b0;
            bram_addr    <= '0;
            bram_din     <= '0;
            status       <= '0;
            done_pulse   <= 1'b0;
        end else begin
            r_arm_hist   <= w_arm;
            r_sw_hist    <= config_snapshot[1];
            r_ext_hist   <= ext_trig;
            r_delay_cnt  <= w_delay_nxt;
            r_sample_cnt <= w_cnt_nxt;
            r_done       <= w_done_nxt;
            r_trig_src   <= w_src_nxt;
            bram_we      <= w_write;
            if (w_write) begin
                bram_addr <= r_sample_cnt[ADDR_WIDTH-1:0];
                bram_din  <= din;
            end
            status     <= {16'(w_cnt_nxt), 11'd0, w_src_nxt, w_done_nxt, w_next_state};
            done_pulse <= (w_next_state == S_DONE) && (r_state != S_DONE);
        end
    end

endmodule

// File: tb/tb_snapshot_ctrl.sv
// tb_snapshot_ctrl: directed vector table plus hand-written capture sequences.
module tb_snapshot_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic [31:0]   cfg;
    logic [31:0]   offset;
    logic          ext_trig;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [31:0]   status;
    logic          done_pulse;

    int n_vec = 0;
    int n_err = 0;

    snapshot_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .axi_clock       (clk),
        .rst             (rst),
        .config_snapshot (cfg),
        .offset_snapshot (offset),
        .ext_trig        (ext_trig),
        .din             (din),
        .din_valid       (din_valid),
        .bram_we         (bram_we),
        .bram_addr       (bram_addr),
        .bram_din        (bram_din),
        .status          (status),
        .done_pulse      (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [31:0] cfg;
        logic [31:0] offset;
        logic        ext;
        logic        dv;
        logic [31:0] din;
        logic [31:0] exp_status;
        logic        exp_we;
        logic        exp_pulse;
        logic [31:0] exp_addr;
        logic [31:0] exp_din;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Outputs sampled 1 time unit after the edge that consumed the inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_status(input int cnt, input bit src, input bit done,
                                              input logic [2:0] st);
        return {cnt[15:0], 11'd0, src, done, st};
    endfunction

    // Re-arm and issue a sw trigger with zero offset; leaves the DUT in CAPTURE.
    task automatic start_capture();
        cfg = 32'h0; din_valid = 1'b0; offset = 32'd0;
        tick();
        cfg = 32'h1;
        tick();
        check("arm_status", status, 32'h1);
        cfg = 32'h3;
        tick();
        check("trig_status", status, 32'h3);
        check("trig_we", {31'd0, bram_we}, 32'd0);
    endtask

    // Runs a capture with a full expected model; stop_at > 0 disarms after that many writes.
    task automatic capture_loop(input bit toggle, input bit use_count, input int stop_at,
                                output int n_writes, output int n_pulses);
        logic [31:0] last_din;
        logic        last_dv;
        logic        exp_we;
        logic        exp_pulse;
        bit          finished;
        n_writes = 0;
        n_pulses = 0;
        finished = 1'b0;
        for (int c = 0; c < 4000 && !finished; c++) begin
            if (stop_at > 0 && n_writes == stop_at) begin
                cfg = 32'h0; din_valid = 1'b1;
                tick();
                check("disarm_status", status, mk_status(stop_at, 1'b0, 1'b0, 3'd0));
                check("disarm_we", {31'd0, bram_we}, 32'd0);
                check("disarm_pulse", {31'd0, done_pulse}, 32'd0);
                finished = 1'b1;
            end else begin
                last_dv   = toggle ? (c % 2 == 0) : 1'b1;
                last_din  = use_count ? 32'(c) : $urandom;
                din       = last_din;
                din_valid = last_dv;
                tick();
                exp_we    = last_dv && (n_writes < DEPTH);
                check("cap_we", {31'd0, bram_we}, {31'd0, exp_we});
                if (exp_we) begin
                    check("cap_addr", {22'd0, bram_addr}, 32'(n_writes));
                    check("cap_din", bram_din, last_din);
                    n_writes++;
                end
                exp_pulse = exp_we && (n_writes == DEPTH);
                check("cap_pulse", {31'd0, done_pulse}, {31'd0, exp_pulse});
                if (done_pulse) n_pulses++;
                check("cap_status", status,
                      mk_status(n_writes, 1'b0, n_writes == DEPTH,
                                (n_writes == DEPTH) ? 3'd4 : 3'd3));
                if (n_writes == DEPTH && !exp_pulse) finished = 1'b1;
            end
        end
        if (!finished) check("cap_timeout", 32'd0, 32'd1);
    endtask

    vec_t vecs[28];
    int   nw;
    int   np;

    initial begin
        rst = 1'b0; cfg = 32'h1; offset = 32'd0; ext_trig = 1'b0;
        din = '0; din_valid = 1'b0;

        //          rst cfg  off  ext dv din            status        we pulse addr din
        vecs[0]  = '{0, 1,   0,   0,  0, 0,             32'h0,        0, 0, 0, 0};
        vecs[1]  = '{0, 1,   0,   0,  0, 0,             32'h0,        0, 0, 0, 0};
        vecs[2]  = '{1, 1,   0,   0,  0, 0,             32'h0,        0, 0, 0, 0};
        vecs[3]  = '{1, 1,   0,   0,  0, 0,             32'h0,        0, 0, 0, 0};
        vecs[4]  = '{1, 0,   0,   0,  0, 0,             32'h0,        0, 0, 0, 0};
        vecs[5]  = '{1, 1,   0,   0,  0, 0,             32'h1,        0, 0, 0, 0};
        vecs[6]  = '{1, 1,   0,   0,  0, 0,             32'h1,        0, 0, 0, 0};
        vecs[7]  = '{1, 1,   0,   1,  0, 0,             32'h1,        0, 0, 0, 0};
        vecs[8]  = '{1, 1,   0,   0,  0, 0,             32'h1,        0, 0, 0, 0};
        vecs[9]  = '{1, 5,   5,   0,  0, 0,             32'h1,        0, 0, 0, 0};
        vecs[10] = '{1, 5,   5,   1,  0, 0,             32'h12,       0, 0, 0, 0};
        vecs[11] = '{1, 5,   5,   1,  0, 0,             32'h12,       0, 0, 0, 0};
        vecs[12] = '{1, 1,   100, 1,  0, 0,             32'h12,       0, 0, 0, 0};
        vecs[13] = '{1, 1,   100, 1,  0, 0,             32'h12,       0, 0, 0, 0};
        vecs[14] = '{1, 1,   100, 1,  0, 0,             32'h12,       0, 0, 0, 0};
        vecs[15] = '{1, 1,   100, 1,  0, 0,             32'h13,       0, 0, 0, 0};
        vecs[16] = '{1, 1,   100, 1,  1, 32'hAAAA5555,  32'h00010013, 1, 0, 0, 32'hAAAA5555};
        vecs[17] = '{1, 1,   100, 1,  0, 0,             32'h00010013, 0, 0, 0, 0};
        vecs[18] = '{1, 0,   100, 1,  1, 0,             32'h00010010, 0, 0, 0, 0};
        vecs[19] = '{1, 2,   100, 1,  0, 0,             32'h00010010, 0, 0, 0, 0};
        vecs[20] = '{1, 1,   100, 1,  0, 0,             32'h1,        0, 0, 0, 0};
        vecs[21] = '{1, 1,   100, 1,  0, 0,             32'h1,        0, 0, 0, 0};
        vecs[22] = '{1, 3,   0,   1,  0, 0,             32'h3,        0, 0, 0, 0};
        vecs[23] = '{1, 0,   0,   1,  0, 0,             32'h0,        0, 0, 0, 0};
        vecs[24] = '{1, 1,   0,   1,  0, 0,             32'h1,        0, 0, 0, 0};
        vecs[25] = '{1, 3,   3,   1,  0, 0,             32'h2,        0, 0, 0, 0};
        vecs[26] = '{1, 1,   3,   1,  0, 0,             32'h2,        0, 0, 0, 0};
        vecs[27] = '{1, 0,   3,   1,  0, 0,             32'h0,        0, 0, 0, 0};

        for (int i = 0; i < 28; i++) begin
            rst       = vecs[i].rst_n;
            cfg       = vecs[i].cfg;
            offset    = vecs[i].offset;
            ext_trig  = vecs[i].ext;
            din_valid = vecs[i].dv;
            din       = vecs[i].din;
            tick();
            check($sformatf("vec%0d_status", i), status, vecs[i].exp_status);
            check($sformatf("vec%0d_we", i), {31'd0, bram_we}, {31'd0, vecs[i].exp_we});
            check($sformatf("vec%0d_pulse", i), {31'd0, done_pulse}, {31'd0, vecs[i].exp_pulse});
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d_addr", i), {22'd0, bram_addr}, vecs[i].exp_addr);
                check($sformatf("vec%0d_din", i), bram_din, vecs[i].exp_din);
            end
        end
        ext_trig = 1'b0;

        // Full capture with din = cycle counter, continuous valid.
        start_capture();
        capture_loop(1'b0, 1'b1, 0, nw, np);
        check("full_writes", 32'(nw), 32'(DEPTH));
        check("full_pulses", 32'(np), 32'd1);
        check("done_status", status, 32'h0400_000C);
        cfg = 32'h0;
        tick();
        check("done_idle_status", status, 32'h0400_0008);

        // Capture with din_valid toggling.
        start_capture();
        capture_loop(1'b1, 1'b0, 0, nw, np);
        check("toggle_writes", 32'(nw), 32'(DEPTH));
        check("toggle_pulses", 32'(np), 32'd1);

        // Disarm after 300 samples, then re-arm clears the count.
        start_capture();
        capture_loop(1'b0, 1'b0, 300, nw, np);
        check("abort_pulses", 32'(np), 32'd0);
        cfg = 32'h1; din_valid = 1'b0;
        tick();
        check("rearm_status", status, 32'h1);

        // Reset in the middle of a capture.
        start_capture();
        din_valid = 1'b1; din = 32'h1234_5678;
        for (int i = 0; i < 5; i++) tick();
        check("pre_rst_we", {31'd0, bram_we}, 32'd1);
        rst = 1'b0;
        tick();
        check("rst_status", status, 32'h0);
        check("rst_we", {31'd0, bram_we}, 32'd0);
        check("rst_addr", {22'd0, bram_addr}, 32'd0);
        check("rst_din", bram_din, 32'd0);
        check("rst_pulse", {31'd0, done_pulse}, 32'd0);
        rst = 1'b1; cfg = 32'h0; din_valid = 1'b0;
        tick();
        check("post_rst_status", status, 32'h0);
        cfg = 32'h6; ext_trig = 1'b1;
        tick();
        check("idle_trig_status", status, 32'h0);
        cfg = 32'h0; ext_trig = 1'b0;
        tick();
        cfg = 32'h1;
        tick();
        check("rst_arm_status", status, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_auto_trig", status, 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
